mem_fill_server: RTL and testbench

MEM_FILL_SERVER -- requirements
Module: mem_fill_server

---
 rtl/mem_pkg.sv | 7 +
 rtl/mem_array.sv | 18 +
 rtl/mem_fill_server.sv | 99 +++++++++
 tb/tb_mem_fill_server.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared FSM state type and default geometry for the fill server.
package mem_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, BURST} fillState_e;
    localparam int LATENCY     = 4;
    localparam int BLOCK_WORDS = 8;
    localparam int MEM_WORDS   = 32768;
endpackage

// File: rtl/mem_array.sv
// mem_array: single-port 16-bit storage, synchronous write, asynchronous read.
module mem_array #(
    parameter int WORDS = 32768,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   wdata,
    output logic [15:0]   rdata
);
    logic [15:0] mem [WORDS];

    always_ff @(posedge clk)
        if (we) mem[addr] <= wdata;

    assign rdata = mem[addr];
endmodule

// File: rtl/mem_fill_server.sv
// mem_fill_server: single-word writes and latency-delayed block-read bursts.
// Define MEM_FILL_CRIT_WORD_FIRST_EN to start bursts at the requested word.
module mem_fill_server
    import mem_pkg::*;
#(
    parameter int LATENCY     = mem_pkg::LATENCY,
    parameter int BLOCK_WORDS = mem_pkg::BLOCK_WORDS,
    parameter int MEM_WORDS   = mem_pkg::MEM_WORDS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_addr,
    output logic [15:0] rsp_data,
    output logic        rsp_last
);
    localparam int OW = $clog2(BLOCK_WORDS);
    localparam int AW = $clog2(MEM_WORDS);
    localparam logic [15:0] BLK_MASK = 16'((1 << (OW + 1)) - 1);

    fillState_e    state, stateNext;
    logic [3:0]    latCnt, latCntNext;
    logic [OW-1:0] beat, beatNext, startOff, startOffNext, offset;
    logic [15:0]   base, baseNext, burstAddr, memAddr, memRdata;
    logic          inBurst, memWe, unusedBits;

    assign inBurst   = state == BURST;
    assign req_ready = state == IDLE;
    assign memWe     = req_valid && req_ready && req_we;
    assign offset    = startOff + beat;
    assign burstAddr = base + 16'({offset, 1'b0});
    // The single array port serves the requester in IDLE and the burst otherwise.
    assign memAddr   = inBurst ? burstAddr : req_addr;
    assign unusedBits = memAddr[0];

    mem_array #(.WORDS(MEM_WORDS), .AW(AW)) u_array (
        .clk  (clk),
        .we   (memWe),
        .addr (memAddr[AW:1]),
        .wdata(req_wdata),
        .rdata(memRdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            latCnt   <= '0;
            beat     <= '0;
            base     <= '0;
            startOff <= '0;
        end else begin
            state    <= stateNext;
            latCnt   <= latCntNext;
            beat     <= beatNext;
            base     <= baseNext;
            startOff <= startOffNext;
        end
    end

    always_comb begin
        stateNext    = state;
        latCntNext   = latCnt;
        beatNext     = beat;
        baseNext     = base;
        startOffNext = startOff;
        case (state)
            IDLE: if (req_valid && !req_we) begin
                baseNext     = req_addr & ~BLK_MASK;
`ifdef MEM_FILL_CRIT_WORD_FIRST_EN
                startOffNext = req_addr[OW:1];
`else
                startOffNext = '0;
`endif
                latCntNext   = 4'(LATENCY - 1);
                stateNext    = LATENCY == 1 ? BURST : WAIT;
            end
            // Leaving on the decrement to zero puts the first beat LATENCY cycles after accept.
            WAIT: begin
                latCntNext = latCnt - 4'd1;
                stateNext  = latCnt == 4'd1 ? BURST : WAIT;
            end
            BURST: begin
                beatNext  = beat + 1'b1;
                stateNext = beat == OW'(BLOCK_WORDS - 1) ? IDLE : BURST;
            end
            default: stateNext = IDLE;
        endcase
    end

    assign rsp_valid = inBurst;
    assign rsp_last  = inBurst && beat == OW'(BLOCK_WORDS - 1);
    assign rsp_addr  = inBurst ? burstAddr : '0;
    assign rsp_data  = inBurst ? memRdata : '0;
endmodule

// File: tb/tb_mem_fill_server.sv
// tb_mem_fill_server: directed and randomized checks of mem_fill_server against a word-array model.
// Honours MEM_FILL_CRIT_WORD_FIRST_EN in the expected beat order.
module tb_mem_fill_server;
    localparam int LAT = 4;
    localparam int BW  = 8;
    localparam int MW  = 32768;
    localparam logic [15:0] BMASK = 16'(~(2 * BW - 1));

    logic        clk = 0, rst = 1, req_valid = 0, req_we = 0;
    logic [15:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, rsp_valid, rsp_last;
    logic [15:0] rsp_addr, rsp_data;
    int          vectors = 0, errs = 0;
    logic [15:0] refMem [int];

    always #5 clk = ~clk;

    mem_fill_server #(.LATENCY(LAT), .BLOCK_WORDS(BW), .MEM_WORDS(MW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_addr(rsp_addr), .rsp_data(rsp_data), .rsp_last(rsp_last)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkIdle(input string tag);
        chk({tag, "_ready"}, 16'(req_ready), 16'd1);
        chk({tag, "_valid"}, 16'(rsp_valid), 16'd0);
        chk({tag, "_last"}, 16'(rsp_last), 16'd0);
        chk({tag, "_addr"}, rsp_addr, 16'd0);
        chk({tag, "_data"}, rsp_data, 16'd0);
    endtask

    // k-th beat address of a read of byte address a: block-aligned base plus wrapped word offset.
    function automatic logic [15:0] beatAddr(input logic [15:0] a, input int k);
        int start;
        start = 0;
`ifdef MEM_FILL_CRIT_WORD_FIRST_EN
        start = (int'(a) % (2 * BW)) / 2;
`endif
        return 16'((int'(a) - int'(a) % (2 * BW)) + 2 * ((start + k) % BW));
    endfunction

    function automatic int wordIdx(input logic [15:0] a);
        return (int'(a) >> 1) % MW;
    endfunction

    task automatic doWrite(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        chk("wr_ready", 16'(req_ready), 16'd1);
        req_valid = 1; req_we = 1; req_addr = a; req_wdata = d;
        @(negedge clk);
        req_valid = 0; req_we = 0;
        refMem[wordIdx(a)] = d;
        chk("wr_norsp", 16'(rsp_valid), 16'd0);
    endtask

    task automatic doRead(input logic [15:0] a, input bit holdWr, input logic [15:0] wa, input logic [15:0] wd);
        logic [15:0] e;
        @(negedge clk);
        chk("rd_ready", 16'(req_ready), 16'd1);
        req_valid = 1; req_we = 0; req_addr = a;
        @(negedge clk);
        if (holdWr) begin
            req_we = 1; req_addr = wa; req_wdata = wd;
        end else req_valid = 0;
        for (int j = 1; j <= LAT + BW - 1; j++) begin
            if (j > 1) @(negedge clk);
            if (j < LAT) begin
                chk("wait_valid", 16'(rsp_valid), 16'd0);
                chk("wait_ready", 16'(req_ready), 16'd0);
            end else begin
                e = beatAddr(a, j - LAT);
                chk("beat_valid", 16'(rsp_valid), 16'd1);
                chk("beat_addr", rsp_addr, e);
                chk("beat_data", rsp_data, refMem[wordIdx(e)]);
                chk("beat_last", 16'(rsp_last), 16'(j - LAT == BW - 1));
                chk("beat_ready", 16'(req_ready), 16'd0);
            end
        end
        @(negedge clk);
        chk("post_ready", 16'(req_ready), 16'd1);
        chk("post_valid", 16'(rsp_valid), 16'd0);
        chk("post_last", 16'(rsp_last), 16'd0);
        if (holdWr) begin
            @(negedge clk);
            req_valid = 0; req_we = 0;
            refMem[wordIdx(wa)] = wd;
        end
    endtask

    initial begin
        logic [15:0] b;
        repeat (2) begin
            @(negedge clk);
            chkIdle("rst0");
        end
        rst = 0;
        for (int i = 0; i < 8; i++) doWrite(16'(16'h0040 + 2 * i), 16'(16'hA000 + i));
        doRead(16'h0040, 0, '0, '0);
        doRead(16'h0046, 0, '0, '0);
        doRead(16'h0040, 1, 16'h0040, 16'hBEEF);
        doRead(16'h0040, 0, '0, '0);
        chk("beef_stored", refMem[wordIdx(16'h0040)], 16'hBEEF);
        // Reset on the third beat of a burst, held for two cycles.
        @(negedge clk);
        req_valid = 1; req_we = 0; req_addr = 16'h0040;
        @(negedge clk);
        req_valid = 0;
        repeat (LAT + 1) @(negedge clk);
        chk("b3_valid", 16'(rsp_valid), 16'd1);
        chk("b3_addr", rsp_addr, beatAddr(16'h0040, 2));
        rst = 1;
        #1 chkIdle("rst_async");
        repeat (2) begin
            @(negedge clk);
            chkIdle("rst_hold");
        end
        rst = 0;
        repeat (BW + LAT) begin
            @(negedge clk);
            chkIdle("rst_after");
        end
        doRead(16'h0040, 0, '0, '0);
        for (int i = 0; i < 8; i++) doWrite(16'(16'hFFF0 + 2 * i), 16'($urandom));
        doRead(16'hFFF0, 0, '0, '0);
        doRead(16'hFFFB, 0, '0, '0);
        for (int it = 0; it < 20; it++) begin
            b = 16'($urandom) & BMASK;
            for (int i = 0; i < BW; i++) doWrite(16'(b + 2 * i) | 16'($urandom_range(0, 1)), 16'($urandom));
            doRead(b | 16'($urandom_range(0, 2 * BW - 1)), bit'($urandom_range(0, 1)),
                   b | 16'(2 * $urandom_range(0, BW - 1)), 16'($urandom));
            doRead(b | 16'($urandom_range(0, 2 * BW - 1)), 0, '0, '0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
